// File: rtl/tagged_multi_fifo_pkg.sv
// Shared helpers and constants for the tag-routed multi-channel FIFO.
// Sizes are derived here so the interface, top and channels agree.
package tagged_fifo_pkg;

    localparam int ERR_OVF = 0;
    localparam int ERR_UDF = 1;
    localparam int ERR_TAG = 2;

    typedef logic [2:0] err_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int tag_w(input int nch);
        return (clog2(nch) < 1) ? 1 : clog2(nch);
    endfunction

endpackage

// File: rtl/tagged_multi_fifo_if.sv
// Producer/consumer bus of the tagged multi-channel FIFO.
// master drives writes and pops; slave is the FIFO itself.
interface tagged_multi_fifo_if #(
    parameter int DW    = 8,
    parameter int NCH   = 2,
    parameter int DEPTH = 8
);
    import tagged_fifo_pkg::*;

    localparam int AW = clog2(DEPTH);

    logic                  wr;
    logic [DW-1:0]         datain;
    logic [NCH-1:0]        rd;
    logic [DW-1:0]         dataout;
    logic                  valid_out;
    logic [NCH-1:0]        full;
    logic [NCH-1:0]        empty;
    logic [NCH-1:0]        almost_full;
    logic [NCH*(AW+1)-1:0] count;
    err_t                  err;

    modport master (
        output wr, datain, rd,
        input  dataout, valid_out, full, empty,
        input  almost_full, count, err
    );

    modport slave (
        input  wr, datain, rd,
        output dataout, valid_out, full, empty,
        output almost_full, count, err
    );

endinterface

// File: rtl/tagged_multi_fifo_channel.sv
// One circular queue with occupancy count and registered flags.
// Push is accepted when not full or when a pop frees a slot this edge.
module fifo_channel
    import tagged_fifo_pkg::*;
#(
    parameter int DW     = 8,
    parameter int DEPTH  = 8,
    parameter int AF_LVL = 6,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic [AW:0]   count
);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_AF   = (AW+1)'(AF_LVL);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          af_q, af_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop  = pop && !empty_q;
        do_push = push && (!full_q || do_pop);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + PTR_ONE;
        if (do_pop)  rptr_d = rptr_q + PTR_ONE;
        if (do_push && !do_pop)
            count_d = count_q + CNT_ONE;
        else if (do_pop && !do_push)
            count_d = count_q - CNT_ONE;
        // Flags follow the next count so they are exact right after the edge.
        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == '0);
        af_d    = (count_d >= CNT_AF);
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
        end
    end

    always_ff @(posedge ck) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

    assign rdata       = mem_q[rptr_q];
    assign full        = full_q;
    assign empty       = empty_q;
    assign almost_full = af_q;
    assign count       = count_q;

endmodule

// File: rtl/tagged_multi_fifo.sv
// N-channel FIFO: words are steered by MSB tag bits, popped by the
// lowest asserted rd bit onto one registered shared output.
module tagged_multi_fifo
    import tagged_fifo_pkg::*;
#(
    parameter int DW     = 8,
    parameter int NCH    = 2,
    parameter int DEPTH  = 8,
    parameter int AF_LVL = 6
) (
    input logic                ck,
    input logic                rst,
    tagged_multi_fifo_if.slave bus
);

    localparam int TW = tag_w(NCH);
    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [TW:0] NCH_T = (TW+1)'(NCH);

    logic [TW-1:0]  tag;
    logic [TW-1:0]  sel_idx;
    logic           sel_any;
    logic [NCH-1:0] push, pop;
    logic [NCH-1:0] full, empty, af;
    logic [DW-1:0]  rdata [NCH];
    logic [CW-1:0]  cnt [NCH];
    logic           bad_tag, ovf, udf;

    logic [DW-1:0]  dataout_q, dataout_d;
    logic           valid_q, valid_d;
    err_t           err_q, err_d;

    always_comb begin
        tag     = bus.datain[DW-1 -: TW];
        bad_tag = bus.wr && ({1'b0, tag} >= NCH_T);
        sel_any = 1'b0;
        sel_idx = '0;
        // Descending scan leaves the lowest requesting channel selected.
        for (int k = NCH - 1; k >= 0; k--) begin
            if (bus.rd[k]) begin
                sel_any = 1'b1;
                sel_idx = TW'(k);
            end
        end
        push      = '0;
        pop       = '0;
        ovf       = 1'b0;
        udf       = 1'b0;
        dataout_d = dataout_q;
        for (int k = 0; k < NCH; k++) begin
            push[k] = bus.wr && (tag == TW'(k));
            pop[k]  = sel_any && (sel_idx == TW'(k)) && !empty[k];
            ovf     = ovf | (push[k] && full[k] && !pop[k]);
            udf     = udf | (sel_any && (sel_idx == TW'(k)) && empty[k]);
            if (pop[k]) dataout_d = rdata[k];
        end
        valid_d          = |pop;
        err_d            = err_q;
        err_d[ERR_OVF]   = err_q[ERR_OVF] | ovf;
        err_d[ERR_UDF]   = err_q[ERR_UDF] | udf;
        err_d[ERR_TAG]   = err_q[ERR_TAG] | bad_tag;
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            dataout_q <= '0;
            valid_q   <= 1'b0;
            err_q     <= '0;
        end else begin
            dataout_q <= dataout_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        fifo_channel #(
            .DW    (DW),
            .DEPTH (DEPTH),
            .AF_LVL(AF_LVL)
        ) u_ch (
            .ck         (ck),
            .rst        (rst),
            .push       (push[k]),
            .pop        (pop[k]),
            .wdata      (bus.datain),
            .rdata      (rdata[k]),
            .full       (full[k]),
            .empty      (empty[k]),
            .almost_full(af[k]),
            .count      (cnt[k])
        );
        assign bus.count[k*CW +: CW] = cnt[k];
    end

    assign bus.dataout     = dataout_q;
    assign bus.valid_out   = valid_q;
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.almost_full = af;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_tagged_multi_fifo.sv
// Directed table plus scoreboard sequences for the tagged multi FIFO,
// on a 2x8 instance and a 3x4 instance with an unused tag value.
module tb_tagged_multi_fifo;

    logic ck = 1'b0;
    logic rst = 1'b1;
    always #5 ck = ~ck;

    tagged_multi_fifo_if #(.DW(8), .NCH(2), .DEPTH(8)) ba ();
    tagged_multi_fifo_if #(.DW(8), .NCH(3), .DEPTH(4)) bb ();

    tagged_multi_fifo #(
        .DW(8), .NCH(2), .DEPTH(8), .AF_LVL(6)
    ) dut_a (.ck(ck), .rst(rst), .bus(ba.slave));

    tagged_multi_fifo #(
        .DW(8), .NCH(3), .DEPTH(4), .AF_LVL(3)
    ) dut_b (.ck(ck), .rst(rst), .bus(bb.slave));

    typedef struct {
        logic       wr;
        logic [7:0] din;
        logic [1:0] rd;
        logic [7:0] dout;
        logic       vld;
        logic [1:0] full;
        logic [1:0] empty;
        logic [1:0] af;
        logic [2:0] err;
        logic [3:0] c0;
        logic [3:0] c1;
    } vec_t;

    vec_t tbl [23];
    int   total = 0;
    int   bad = 0;

    logic [7:0] mq [4][$];
    logic [2:0] merr;
    logic [7:0] mdout;
    logic       mvld;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mkv(
        input logic wr, input logic [7:0] din, input logic [1:0] rd,
        input logic [7:0] dout, input logic vld, input logic [1:0] full,
        input logic [1:0] empty, input logic [1:0] af,
        input logic [2:0] err, input logic [3:0] c0, input logic [3:0] c1);
        vec_t v;
        v.wr = wr; v.din = din; v.rd = rd; v.dout = dout; v.vld = vld;
        v.full = full; v.empty = empty; v.af = af; v.err = err;
        v.c0 = c0; v.c1 = c1;
        return v;
    endfunction

    task automatic mreset(input logic [7:0] dout);
        for (int k = 0; k < 4; k++) mq[k].delete();
        merr  = '0;
        mdout = dout;
        mvld  = 1'b0;
    endtask

    // Reference behaviour: pop is resolved against pre-edge contents first.
    task automatic mstep(input int nch, input int depth, input logic wr,
                         input logic [7:0] din, input logic [3:0] rd);
        int tg;
        int s;
        s  = -1;
        tg = (nch == 2) ? int'(din[7]) : int'(din[7:6]);
        for (int k = nch - 1; k >= 0; k--) if (rd[k]) s = k;
        mvld = 1'b0;
        if (s >= 0) begin
            if (mq[s].size() > 0) begin
                mdout = mq[s].pop_front();
                mvld  = 1'b1;
            end else begin
                merr[1] = 1'b1;
            end
        end
        if (wr) begin
            if (tg >= nch) merr[2] = 1'b1;
            else if (mq[tg].size() < depth) mq[tg].push_back(din);
            else merr[0] = 1'b1;
        end
    endtask

    task automatic chk_model(input string p, input int nch, input int depth,
                             input int aflvl, input logic [7:0] dout,
                             input logic vld, input logic [2:0] err,
                             input logic [15:0] cnt, input logic [3:0] full,
                             input logic [3:0] empty, input logic [3:0] af);
        int cw;
        int sz;
        cw = (nch == 2) ? 4 : 3;
        chk({p, "_dout"}, 32'(dout), 32'(mdout));
        chk({p, "_vld"}, 32'(vld), 32'(mvld));
        chk({p, "_err"}, 32'(err), 32'(merr));
        for (int k = 0; k < nch; k++) begin
            sz = mq[k].size();
            chk($sformatf("%s_cnt%0d", p, k),
                (32'(cnt) >> (k * cw)) & ((32'd1 << cw) - 1), 32'(sz));
            chk($sformatf("%s_full%0d", p, k), 32'(full[k]), 32'(sz == depth));
            chk($sformatf("%s_empty%0d", p, k), 32'(empty[k]), 32'(sz == 0));
            chk($sformatf("%s_af%0d", p, k), 32'(af[k]), 32'(sz >= aflvl));
        end
    endtask

    task automatic drive_a(input logic wr, input logic [7:0] din,
                           input logic [1:0] rd);
        ba.wr = wr; ba.datain = din; ba.rd = rd;
        @(posedge ck); #1;
        mstep(2, 8, wr, din, {2'b00, rd});
        chk_model("a", 2, 8, 6, ba.dataout, ba.valid_out, ba.err,
                  16'(ba.count), {2'b00, ba.full}, {2'b00, ba.empty},
                  {2'b00, ba.almost_full});
    endtask

    task automatic drive_b(input logic wr, input logic [7:0] din,
                           input logic [2:0] rd);
        bb.wr = wr; bb.datain = din; bb.rd = rd;
        @(posedge ck); #1;
        mstep(3, 4, wr, din, {1'b0, rd});
        chk_model("b", 3, 4, 3, bb.dataout, bb.valid_out, bb.err,
                  16'(bb.count), {1'b0, bb.full}, {1'b0, bb.empty},
                  {1'b0, bb.almost_full});
    endtask

    initial begin
        ba.wr = 1'b0; ba.datain = '0; ba.rd = '0;
        bb.wr = 1'b0; bb.datain = '0; bb.rd = '0;

        for (int i = 0; i < 8; i++)
            tbl[i] = mkv(1'b1, 8'(8'h81 + i), 2'b00, 8'h00, 1'b0,
                         (i == 7) ? 2'b10 : 2'b00, 2'b01,
                         (i >= 5) ? 2'b10 : 2'b00, 3'b000, 4'd0, 4'(i + 1));
        for (int i = 0; i < 3; i++)
            tbl[8+i] = mkv(1'b1, 8'(8'h01 + i), 2'b00, 8'h00, 1'b0,
                           2'b10, 2'b00, 2'b10, 3'b000, 4'(i + 1), 4'd8);
        tbl[11] = mkv(1'b1, 8'h89, 2'b00, 8'h00, 1'b0,
                      2'b10, 2'b00, 2'b10, 3'b001, 4'd3, 4'd8);
        for (int i = 0; i < 8; i++)
            tbl[12+i] = mkv(1'b0, 8'h00, 2'b10, 8'(8'h81 + i), 1'b1,
                            2'b00, (i == 7) ? 2'b10 : 2'b00,
                            (i <= 1) ? 2'b10 : 2'b00, 3'b001, 4'd3, 4'(7 - i));
        tbl[20] = mkv(1'b0, 8'h00, 2'b10, 8'h88, 1'b0,
                      2'b00, 2'b10, 2'b00, 3'b011, 4'd3, 4'd0);
        tbl[21] = mkv(1'b1, 8'h90, 2'b00, 8'h88, 1'b0,
                      2'b00, 2'b00, 2'b00, 3'b011, 4'd3, 4'd1);
        tbl[22] = mkv(1'b0, 8'h00, 2'b11, 8'h01, 1'b1,
                      2'b00, 2'b00, 2'b00, 3'b011, 4'd2, 4'd1);

        #12 rst = 1'b0;
        @(posedge ck); #1;
        chk("rst_dout", 32'(ba.dataout), 32'h0);
        chk("rst_vld", 32'(ba.valid_out), 32'h0);
        chk("rst_empty", 32'(ba.empty), 32'h3);
        chk("rst_full", 32'(ba.full), 32'h0);
        chk("rst_af", 32'(ba.almost_full), 32'h0);
        chk("rst_err", 32'(ba.err), 32'h0);
        chk("rst_b_empty", 32'(bb.empty), 32'h7);

        for (int i = 0; i < 23; i++) begin
            ba.wr = tbl[i].wr; ba.datain = tbl[i].din; ba.rd = tbl[i].rd;
            @(posedge ck); #1;
            chk($sformatf("v%0d_dout", i), 32'(ba.dataout), 32'(tbl[i].dout));
            chk($sformatf("v%0d_vld", i), 32'(ba.valid_out), 32'(tbl[i].vld));
            chk($sformatf("v%0d_full", i), 32'(ba.full), 32'(tbl[i].full));
            chk($sformatf("v%0d_empty", i), 32'(ba.empty), 32'(tbl[i].empty));
            chk($sformatf("v%0d_af", i), 32'(ba.almost_full), 32'(tbl[i].af));
            chk($sformatf("v%0d_err", i), 32'(ba.err), 32'(tbl[i].err));
            chk($sformatf("v%0d_c0", i), 32'(ba.count[3:0]), 32'(tbl[i].c0));
            chk($sformatf("v%0d_c1", i), 32'(ba.count[7:4]), 32'(tbl[i].c1));
        end

        ba.wr = 1'b1; ba.datain = 8'h85; ba.rd = 2'b00;
        @(posedge ck); #3;
        rst = 1'b1;
        #1;
        chk("amid_dout", 32'(ba.dataout), 32'h0);
        chk("amid_vld", 32'(ba.valid_out), 32'h0);
        chk("amid_err", 32'(ba.err), 32'h0);
        chk("amid_empty", 32'(ba.empty), 32'h3);
        chk("amid_full", 32'(ba.full), 32'h0);
        chk("amid_count", 32'(ba.count), 32'h0);
        ba.wr = 1'b0;
        @(posedge ck); #3;
        rst = 1'b0;

        ba.wr = 1'b1; ba.datain = 8'h11;
        @(posedge ck); #1;
        ba.datain = 8'h92;
        @(posedge ck); #1;
        ba.wr = 1'b0; ba.rd = 2'b01;
        @(posedge ck); #1;
        chk("post_rd0", 32'(ba.dataout), 32'h11);
        chk("post_vld0", 32'(ba.valid_out), 32'h1);
        ba.rd = 2'b10;
        @(posedge ck); #1;
        chk("post_rd1", 32'(ba.dataout), 32'h92);
        chk("post_cnt", 32'(ba.count), 32'h0);

        mreset(8'h92);
        for (int i = 0; i < 8; i++) drive_a(1'b1, 8'(8'h20 + i), 2'b00);
        drive_a(1'b1, 8'h7F, 2'b01);
        chk("simul_dout", 32'(ba.dataout), 32'h20);
        chk("simul_c0", 32'(ba.count[3:0]), 32'h8);
        chk("simul_ovf", 32'(ba.err[0]), 32'h0);
        for (int i = 0; i < 40; i++)
            drive_a($urandom_range(0, 9) < 6, 8'($urandom),
                    2'($urandom_range(0, 3)));
        ba.wr = 1'b0; ba.rd = 2'b00;

        @(posedge ck); #2;
        rst = 1'b1;
        #2 rst = 1'b0;
        @(posedge ck); #1;
        mreset(8'h00);
        drive_b(1'b1, 8'hC5, 3'b000);
        chk("b_tag3_err", 32'(bb.err), 32'h4);
        chk("b_tag3_cnt", 32'(bb.count), 32'h0);
        drive_b(1'b1, 8'h41, 3'b000);
        drive_b(1'b1, 8'h82, 3'b000);
        drive_b(1'b1, 8'h03, 3'b100);
        for (int i = 0; i < 60; i++)
            drive_b($urandom_range(0, 9) < 6, 8'($urandom),
                    3'($urandom_range(0, 7)));
        bb.wr = 1'b0; bb.rd = 3'b000;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
